// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU16 multiply/divide sequencer: FSM states,
// operation encodings and the default iteration count.
package alu_seq_pkg;

  localparam int ITER_CNT = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_ITER,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/rca_muldiv_seq.sv
// Time-shares the ALU's single (WIDTH+1)-bit ripple-carry adder to run signed
// radix-2 Booth multiply and unsigned non-restoring divide, one add per cycle.
module rca_muldiv_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ITER_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [WIDTH:0]   add_x,
  output logic [WIDTH:0]   add_y,
  output logic             add_ci,
  input  logic [WIDTH:0]   add_z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_e       r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH:0]   r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  logic [WIDTH:0]   w_add_x;
  logic [WIDTH:0]   w_add_y;
  logic             w_add_ci;

  // Adder operand steering; IDLE/DONE leave the adder at 0+0+0.
  always_comb begin
    w_add_x  = '0;
    w_add_y  = '0;
    w_add_ci = 1'b0;
    case (r_state)
      ST_MUL_ITER: begin
        w_add_x = r_a;
        case ({r_q[0], r_qm1})
          2'b01:   w_add_y = r_m;
          2'b10: begin
            w_add_y  = ~r_m;
            w_add_ci = 1'b1;
          end
          default: w_add_y = '0;
        endcase
      end
      ST_DIV_ITER: begin
        w_add_x = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
        if (!r_a[WIDTH]) begin
          w_add_y  = ~r_m;
          w_add_ci = 1'b1;
        end else begin
          w_add_y = r_m;
        end
      end
      ST_DIV_FIX: begin
        // Negative partial remainder needs one restoring add; otherwise pass A through.
        w_add_x = r_a;
        w_add_y = r_a[WIDTH] ? r_m : '0;
      end
      default: ;
    endcase
  end

  assign add_x       = w_add_x;
  assign add_y       = w_add_y;
  assign add_ci      = w_add_ci;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign result_hi   = r_res_hi;
  assign result_lo   = r_res_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dbz <= 1'b0;
            r_a   <= '0;
            r_q   <= a;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_m   <= (op_div == OP_DIV) ? {1'b0, b} : {b[WIDTH-1], b};
            if (op_div == OP_DIV && b == '0) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_dbz    <= 1'b1;
              r_res_hi <= a;
              r_res_lo <= '1;
            end else begin
              r_state <= (op_div == OP_DIV) ? ST_DIV_ITER : ST_MUL_ITER;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL_ITER: begin
          // Arithmetic shift right of {sum, Q, Qm1}.
          r_a   <= {add_z[WIDTH], add_z[WIDTH:1]};
          r_q   <= {add_z[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_res_hi <= add_z[WIDTH:1];
            r_res_lo <= {add_z[0], r_q[WIDTH-1:1]};
          end
        end
        ST_DIV_ITER: begin
          r_a   <= add_z;
          r_q   <= {r_q[WIDTH-2:0], ~add_z[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          r_a      <= add_z;
          r_state  <= ST_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_res_hi <= add_z[WIDTH-1:0];
          r_res_lo <= r_q;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_muldiv_seq.sv
// Directed bench for rca_muldiv_seq, closing the adder loop with a 17-bit add.
module tb_rca_muldiv_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_div;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         div_by_zero;
  logic [W:0]   add_x;
  logic [W:0]   add_y;
  logic         add_ci;
  logic [W:0]   add_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign add_z = add_x + add_y + {{W{1'b0}}, add_ci};

  rca_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .add_x(add_x), .add_y(add_y), .add_ci(add_ci),
    .add_z(add_z)
  );

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cycles);
    start = 1'b1; op_div = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: done never seen after %0d cycles, required within 40", lat);
    end
  endtask

  task automatic check_res(input string name, input logic [2*W-1:0] exp);
    checks++;
    if ({result_hi, result_lo} !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, {result_hi, result_lo}, exp);
    end
  endtask

  task automatic check_lat(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: latency %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_div = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, result_hi, result_lo} !== '0 ||
        {add_x, add_y, add_ci} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b res=0x%h%h add=%h/%h/%b, required all 0",
               busy, done, div_by_zero, result_hi, result_lo, add_x, add_y, add_ci);
    end
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(1'b0, 16'd3, 16'hFFFB, lat, bc);
    check_lat("mul_3x-5_latency", lat, 17);
    check_res("mul_3x-5", 32'hFFFF_FFF1);
    checks++;
    if (bc !== 16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy: busy cycles %0d (busy at done %b), required 16 (0)", bc, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b one cycle after done, required 0", done);
    end
    check_res("mul_hold_idle", 32'hFFFF_FFF1);
    run_op(1'b0, 16'h8000, 16'h8000, lat, bc);
    check_res("mul_min_x_min", 32'h4000_0000);
    @(negedge clk);
    run_op(1'b0, 16'h7FFF, 16'h8000, lat, bc);
    check_res("mul_max_x_min", 32'hC000_8000);
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(1'b1, 16'd1000, 16'd7, lat, bc);
    check_lat("div_1000_7_latency", lat, 18);
    check_res("div_1000_7", {16'h0006, 16'h008E});
    @(negedge clk);
    run_op(1'b1, 16'hFFFF, 16'd1, lat, bc);
    check_res("div_ffff_1", {16'h0000, 16'hFFFF});
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    run_op(1'b1, 16'd5, 16'd0, lat, bc);
    check_lat("dbz_latency", lat, 1);
    check_res("dbz_result", {16'h0005, 16'hFFFF});
    checks++;
    if (div_by_zero !== 1'b1 || bc !== 0) begin
      errors++;
      $display("FAIL dbz_flag: div_by_zero=%b busy cycles %0d, required 1 and 0", div_by_zero, bc);
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: div_by_zero=%b in idle, required 1", div_by_zero);
    end
    start = 1'b1; op_div = 1'b0; a_in = 16'd2; b_in = 16'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dbz_clear: div_by_zero=%b busy=%b after new start, required 0 and 1",
               div_by_zero, busy);
    end
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    check_res("mul_after_dbz", 32'h0000_0006);
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat;
    start = 1'b1; op_div = 1'b0; a_in = 16'd3; b_in = 16'hFFFB;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; op_div = 1'b1; a_in = 16'd5; b_in = 16'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_lat("ignored_start_latency", lat, 17);
    check_res("ignored_start_result", 32'hFFFF_FFF1);
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_dbz: div_by_zero=%b, required 0", div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(1'b0, 16'd3, 16'hFFFB, lat, bc);
    run_op(1'b1, 16'd1000, 16'd7, lat, bc);
    check_lat("b2b_div_latency", lat, 18);
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL b2b_busy: busy cycles %0d, required 17", bc);
    end
    check_res("b2b_div_result", {16'h0006, 16'h008E});
    @(negedge clk);
  endtask

  task automatic test_rst_mid_op();
    int lat, bc;
    start = 1'b1; op_div = 1'b1; a_in = 16'd1000; b_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, result_hi, result_lo} !== '0 || add_x !== '0) begin
      errors++;
      $display("FAIL rst_mid_op: busy=%b done=%b res=0x%h%h add_x=%h, required all 0",
               busy, done, result_hi, result_lo, add_x);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        checks++; errors++;
        $display("FAIL rst_no_done: done=1 after abort, required 0");
        break;
      end
    end
    rst = 1'b1; start = 1'b1; op_div = 1'b0; a_in = 16'd9; b_in = 16'd9;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_start: busy=%b, required 0", busy);
    end
    run_op(1'b0, 16'd12, 16'd12, lat, bc);
    check_lat("mul_12x12_latency", lat, 17);
    check_res("mul_12x12", 32'h0000_0090);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_rst_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
